// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: fetch FSM states and the canonical NOP encoding.
package rv32i_types;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {instr, pc} skid buffer that parks a fetched word while decode is stalled.
module fetch_hold_buf #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [width-1:0] instr_in,
  input  logic [width-1:0] pc_in,
  output logic [width-1:0] instr,
  output logic [width-1:0] pc,
  output logic             valid
);

  // Clear wins over load so a flush can never leave a stale word behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc    <= pc_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, runs the imem
// handshake, parks words across decode stalls and discards stale responses
// after a redirect. Optional build macro FETCH_STATS_EN adds fetch/stall counters.
module fetch_stage
  import rv32i_types::*;
#(
  parameter int unsigned      width    = 32,
  parameter logic [width-1:0] RESET_PC = 32'h40000060
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_signal,
  input  logic             redirect_i,
  input  logic [width-1:0] redirect_pc_i,
  output logic             imem_read_o,
  output logic [width-1:0] imem_address_o,
  input  logic             imem_resp_i,
  input  logic [width-1:0] imem_rdata_i,
  output logic [width-1:0] IF_instr_o,
  output logic [width-1:0] IF_pc_out_o,
  output logic             IF_valid_o
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]      fetch_count_o,
  output logic [31:0]      stall_count_o
`endif
);

  localparam logic [width-1:0] NOP = width'(NOP_INSTR);

  fetch_state_t     state_q, state_d;
  logic [width-1:0] pc_d;
  logic [width-1:0] instr_d;
  logic [width-1:0] ifpc_d;
  logic             valid_d;
  logic             buf_load;
  logic             buf_clear;
  logic [width-1:0] buf_instr;
  logic [width-1:0] buf_pc;
  logic             buf_valid;

  fetch_hold_buf #(.width(width)) u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .clear    (buf_clear),
    .instr_in (imem_rdata_i),
    .pc_in    (imem_address_o),
    .instr    (buf_instr),
    .pc       (buf_pc),
    .valid    (buf_valid)
  );

  // State, PC, request strobe and IF/ID register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= FETCH;
      imem_address_o <= RESET_PC;
      imem_read_o    <= 1'b1;
      IF_instr_o     <= NOP;
      IF_pc_out_o    <= '0;
      IF_valid_o     <= 1'b0;
    end else begin
      state_q        <= state_d;
      imem_address_o <= pc_d;
      imem_read_o    <= (state_d == FETCH);
      IF_instr_o     <= instr_d;
      IF_pc_out_o    <= ifpc_d;
      IF_valid_o     <= valid_d;
    end
  end

  // Next-state, next-PC and IF/ID update; redirect overrides stall and resp.
  always_comb begin
    state_d   = state_q;
    pc_d      = imem_address_o;
    instr_d   = IF_instr_o;
    ifpc_d    = IF_pc_out_o;
    valid_d   = IF_valid_o;
    buf_load  = 1'b0;
    buf_clear = 1'b0;

    if (redirect_i) begin
      pc_d      = redirect_pc_i;
      valid_d   = 1'b0;
      instr_d   = NOP;
      buf_clear = 1'b1;
      case (state_q)
        FETCH:   state_d = imem_resp_i ? FETCH : DISCARD;
        HOLD:    state_d = FETCH;
        DISCARD: state_d = imem_resp_i ? FETCH : DISCARD;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_resp_i) begin
            pc_d = imem_address_o + width'(4);
            if (stall_signal) begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end else begin
              instr_d = imem_rdata_i;
              ifpc_d  = imem_address_o;
              valid_d = 1'b1;
            end
          end else if (!stall_signal) begin
            instr_d = NOP;
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall_signal) begin
            instr_d   = buf_instr;
            ifpc_d    = buf_pc;
            valid_d   = buf_valid;
            buf_clear = 1'b1;
            state_d   = FETCH;
          end
        end
        DISCARD: begin
          if (imem_resp_i) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic fetch_load;

  assign fetch_load = !redirect_i && !stall_signal &&
                      ((state_q == FETCH && imem_resp_i) || (state_q == HOLD));

  // Free-running wrap-around counters of accepted instructions and stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_o <= '0;
      stall_count_o <= '0;
    end else begin
      if (fetch_load) begin
        fetch_count_o <= fetch_count_o + 32'd1;
      end
      if (stall_signal) begin
        stall_count_o <= stall_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage; define FETCH_STATS_EN to also check counters.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall_signal;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_read_o;
  logic [31:0] imem_address_o;
  logic        imem_resp_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] IF_instr_o;
  logic [31:0] IF_pc_out_o;
  logic        IF_valid_o;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_o;
  logic [31:0] stall_count_o;
`endif

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall_signal   (stall_signal),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .imem_read_o    (imem_read_o),
    .imem_address_o (imem_address_o),
    .imem_resp_i    (imem_resp_i),
    .imem_rdata_i   (imem_rdata_i),
    .IF_instr_o     (IF_instr_o),
    .IF_pc_out_o    (IF_pc_out_o),
    .IF_valid_o     (IF_valid_o)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count_o  (fetch_count_o),
    .stall_count_o  (stall_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        resp;
    logic [31:0] rdata;
    logic        exp_read;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic rd, input logic [31:0] addr,
                            input logic vld, input logic [31:0] instr, input logic [31:0] pc);
    check({tag, ".read"},  32'(imem_read_o), 32'(rd));
    check({tag, ".addr"},  imem_address_o,   addr);
    check({tag, ".valid"}, 32'(IF_valid_o),  32'(vld));
    check({tag, ".instr"}, IF_instr_o,       instr);
    check({tag, ".pc"},    IF_pc_out_o,      pc);
  endtask

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic rs, input logic [31:0] dat, input logic er,
                              input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                              input logic [31:0] ep);
    vec_t v;
    v.stall = st; v.redir = rd; v.rpc = rpc; v.resp = rs; v.rdata = dat;
    v.exp_read = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_instr = ei; v.exp_pc = ep;
    return v;
  endfunction

  initial begin
    // stall redir rpc resp rdata | read addr valid instr pc (after the edge)
    vecs[0]  = mk(0,0,0,           1,32'h40000060, 1,32'h40000064,1,32'h40000060,32'h40000060);
    vecs[1]  = mk(0,0,0,           1,32'h40000064, 1,32'h40000068,1,32'h40000064,32'h40000064);
    vecs[2]  = mk(0,0,0,           1,32'h40000068, 1,32'h4000006C,1,32'h40000068,32'h40000068);
    vecs[3]  = mk(1,0,0,           1,32'hAAAA0001, 0,32'h40000070,1,32'h40000068,32'h40000068);
    vecs[4]  = mk(1,0,0,           0,32'h0,        0,32'h40000070,1,32'h40000068,32'h40000068);
    vecs[5]  = mk(1,0,0,           1,32'hDEADBEEF, 0,32'h40000070,1,32'h40000068,32'h40000068);
    vecs[6]  = mk(0,0,0,           0,32'h0,        1,32'h40000070,1,32'hAAAA0001,32'h4000006C);
    vecs[7]  = mk(0,0,0,           0,32'h0,        1,32'h40000070,0,32'h00000013,32'h4000006C);
    vecs[8]  = mk(0,1,32'h40000100,0,32'h0,        0,32'h40000100,0,32'h00000013,32'h4000006C);
    vecs[9]  = mk(0,0,0,           0,32'h0,        0,32'h40000100,0,32'h00000013,32'h4000006C);
    vecs[10] = mk(0,0,0,           1,32'h0BADBAD0, 1,32'h40000100,0,32'h00000013,32'h4000006C);
    vecs[11] = mk(0,0,0,           1,32'h12345678, 1,32'h40000104,1,32'h12345678,32'h40000100);
    vecs[12] = mk(0,1,32'h40000200,1,32'h00000055, 1,32'h40000200,0,32'h00000013,32'h40000100);
    vecs[13] = mk(0,0,0,           1,32'h00000066, 1,32'h40000204,1,32'h00000066,32'h40000200);
    vecs[14] = mk(1,1,32'h40000300,0,32'h0,        0,32'h40000300,0,32'h00000013,32'h40000200);
    vecs[15] = mk(1,0,0,           1,32'h0BADF00D, 1,32'h40000300,0,32'h00000013,32'h40000200);
    vecs[16] = mk(0,0,0,           1,32'h00000077, 1,32'h40000304,1,32'h00000077,32'h40000300);
    vecs[17] = mk(0,1,32'hFFFFFFFC,1,32'h0000005A, 1,32'hFFFFFFFC,0,32'h00000013,32'h40000300);
    vecs[18] = mk(0,0,0,           1,32'h00000088, 1,32'h00000000,1,32'h00000088,32'hFFFFFFFC);
    vecs[19] = mk(1,0,0,           1,32'h00000099, 0,32'h00000004,1,32'h00000088,32'hFFFFFFFC);
    vecs[20] = mk(1,1,32'h40000400,0,32'h0,        1,32'h40000400,0,32'h00000013,32'hFFFFFFFC);
    vecs[21] = mk(1,0,0,           1,32'h000000AB, 0,32'h40000404,0,32'h00000013,32'hFFFFFFFC);
    vecs[22] = mk(0,0,0,           0,32'h0,        1,32'h40000404,1,32'h000000AB,32'h40000400);

    rst = 1'b1; stall_signal = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_resp_i = 1'b0; imem_rdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outs("reset", 1'b1, 32'h40000060, 1'b0, 32'h00000013, 32'h0);

    // Table-driven main sequence: stream, stall/hold, redirects, wrap.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      stall_signal  = vecs[i].stall;
      redirect_i    = vecs[i].redir;
      redirect_pc_i = vecs[i].rpc;
      imem_resp_i   = vecs[i].resp;
      imem_rdata_i  = vecs[i].rdata;
      @(posedge clk);
      #1;
      check_outs($sformatf("v%0d", i), vecs[i].exp_read, vecs[i].exp_addr,
                 vecs[i].exp_valid, vecs[i].exp_instr, vecs[i].exp_pc);
    end

    // Asynchronous reset while parked in HOLD.
    @(negedge clk);
    stall_signal = 1'b1; redirect_i = 1'b0; imem_resp_i = 1'b1; imem_rdata_i = 32'h000000CC;
    @(posedge clk);
    #1;
    check("hold.read", 32'(imem_read_o), 32'd0);
    @(negedge clk);
    imem_resp_i = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 1'b1, 32'h40000060, 1'b0, 32'h00000013, 32'h0);
    @(negedge clk);
    rst = 1'b0; stall_signal = 1'b0;
    @(posedge clk);
    #1;
    check_outs("post_rst", 1'b1, 32'h40000060, 1'b0, 32'h00000013, 32'h0);

    // Ten back-to-back fetches then four stall cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      imem_resp_i = 1'b1; imem_rdata_i = 32'(i);
      @(posedge clk);
    end
    #1;
    check_outs("ten", 1'b1, 32'h40000088, 1'b1, 32'h00000009, 32'h40000084);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      imem_resp_i = 1'b0; stall_signal = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    stall_signal = 1'b0;
    check_outs("stalled", 1'b1, 32'h40000088, 1'b1, 32'h00000009, 32'h40000084);
`ifdef FETCH_STATS_EN
    check("fetch_count", fetch_count_o, 32'd10);
    check("stall_count", stall_count_o, 32'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
